// File: rtl/branch_pkg.sv
// Shared definitions for the branch resolve unit: branch-kind encoding and PC step.
package branch_pkg;

  typedef enum logic [2:0] {
    BEQ  = 3'b000,
    BNE  = 3'b001,
    BLT  = 3'b100,
    BGE  = 3'b101,
    BLTU = 3'b110,
    BGEU = 3'b111
  } funct3_e;

  localparam int unsigned PC_INC = 4;

endpackage

// File: rtl/comparator_eq.sv
// Equality comparator used for the BEQ/BNE conditions.
module comparator_eq #(
  parameter int N = 32
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         eq
);

  assign eq = (a == b);

endmodule

// File: rtl/branch_resolve_unit.sv
// Resolves a conditional branch into direction, next PC and mispredict flag behind one
// ready/valid result register. Optional counters are enabled with BRANCH_RESOLVE_STATS_EN.
module branch_resolve_unit
  import branch_pkg::*;
#(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [2:0]   funct3,
  input  logic [N-1:0] rs1,
  input  logic [N-1:0] rs2,
  input  logic [N-1:0] pc,
  input  logic [N-1:0] imm,
  input  logic         pred_taken,
  input  logic         flush,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         taken,
  output logic [N-1:0] target,
  output logic         mispredict,
`ifdef BRANCH_RESOLVE_STATS_EN
  output logic [31:0]  branch_count,
  output logic [31:0]  mispredict_count,
`endif
  output logic         illegal
);

  logic         validQ;
  logic         takenQ;
  logic         mispredictQ;
  logic         illegalQ;
  logic [N-1:0] targetQ;

  logic         eq;
  logic         ltSigned;
  logic         ltUnsigned;
  logic         takenD;
  logic         illegalD;
  logic         mispredictD;
  logic [N-1:0] targetD;
  logic         capture;
  logic         outHandshake;

  comparator_eq #(.N(N)) uEq (
    .a  (rs1),
    .b  (rs2),
    .eq (eq)
  );

  assign in_ready     = (!validQ || out_ready) && !flush;
  assign capture      = in_valid && in_ready;
  assign outHandshake = validQ && out_ready;

  assign ltSigned   = $signed(rs1) < $signed(rs2);
  assign ltUnsigned = rs1 < rs2;

  always_comb begin
    takenD   = 1'b0;
    illegalD = 1'b0;
    case (funct3)
      BEQ:     takenD = eq;
      BNE:     takenD = !eq;
      BLT:     takenD = ltSigned;
      BGE:     takenD = !ltSigned;
      BLTU:    takenD = ltUnsigned;
      BGEU:    takenD = !ltUnsigned;
      default: illegalD = 1'b1;
    endcase
    // Illegal kinds never take, so this also yields pred_taken for them.
    mispredictD = takenD ^ pred_taken;
    targetD     = takenD ? (pc + imm) : (pc + N'(PC_INC));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      validQ      <= 1'b0;
      takenQ      <= 1'b0;
      mispredictQ <= 1'b0;
      illegalQ    <= 1'b0;
      targetQ     <= '0;
    end else if (flush) begin
      validQ <= 1'b0;
    end else if (capture) begin
      validQ      <= 1'b1;
      takenQ      <= takenD;
      mispredictQ <= mispredictD;
      illegalQ    <= illegalD;
      targetQ     <= targetD;
    end else if (outHandshake) begin
      validQ <= 1'b0;
    end
  end

  assign out_valid  = validQ;
  assign taken      = takenQ;
  assign target     = targetQ;
  assign mispredict = mispredictQ;
  assign illegal    = illegalQ;

`ifdef BRANCH_RESOLVE_STATS_EN
  logic [31:0] branchCountQ;
  logic [31:0] mispredictCountQ;

  // A result delivered in a flush cycle still counts; reset clears the totals.
  always_ff @(posedge clk) begin
    if (rst) begin
      branchCountQ     <= '0;
      mispredictCountQ <= '0;
    end else if (outHandshake) begin
      if (branchCountQ != 32'hFFFF_FFFF) begin
        branchCountQ <= branchCountQ + 32'd1;
      end
      if (mispredictQ && (mispredictCountQ != 32'hFFFF_FFFF)) begin
        mispredictCountQ <= mispredictCountQ + 32'd1;
      end
    end
  end

  assign branch_count     = branchCountQ;
  assign mispredict_count = mispredictCountQ;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Randomized self-checking bench for branch_resolve_unit against a behavioural model;
// counter checks are compiled in when BRANCH_RESOLVE_STATS_EN is defined.
module tb_branch_resolve_unit;

  localparam int N = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   funct3;
  logic [N-1:0] rs1, rs2, pc, imm;
  logic         pred_taken;
  logic         flush;
  logic         out_valid;
  logic         out_ready;
  logic         taken;
  logic [N-1:0] target;
  logic         mispredict;
  logic         illegal;
`ifdef BRANCH_RESOLVE_STATS_EN
  logic [31:0]  branch_count;
  logic [31:0]  mispredict_count;
`endif

  branch_resolve_unit #(.N(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .funct3     (funct3),
    .rs1        (rs1),
    .rs2        (rs2),
    .pc         (pc),
    .imm        (imm),
    .pred_taken (pred_taken),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .taken      (taken),
    .target     (target),
    .mispredict (mispredict),
`ifdef BRANCH_RESOLVE_STATS_EN
    .branch_count     (branch_count),
    .mispredict_count (mispredict_count),
`endif
    .illegal    (illegal)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference state: what the consumer should see after each edge.
  bit          mValid, mTaken, mMis, mIll;
  logic [31:0] mTarget;
  longint      mBranches, mMispredicts;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void refResolve(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                                     input logic [31:0] p, input logic [31:0] im, input bit pred,
                                     output bit tk, output bit ill, output bit mis,
                                     output logic [31:0] tgt);
    longint unsigned sum;
    ill = 0;
    tk  = 0;
    case (f3)
      3'd0: tk = (a == b);
      3'd1: tk = (a != b);
      3'd4: tk = (int'(a) < int'(b));
      3'd5: tk = !(int'(a) < int'(b));
      3'd6: tk = (longint'(a) < longint'(b));
      3'd7: tk = !(longint'(a) < longint'(b));
      default: ill = 1;
    endcase
    sum = tk ? (longint'(p) + longint'(im)) : (longint'(p) + 4);
    tgt = 32'(sum % 64'h1_0000_0000);
    mis = tk != pred;
  endfunction

  task automatic applyStimulus(input bit r, input bit v, input logic [2:0] f3, input logic [31:0] a,
                               input logic [31:0] b, input logic [31:0] p, input logic [31:0] im,
                               input bit pred, input bit ordy, input bit fl);
    rst = r; in_valid = v; funct3 = f3; rs1 = a; rs2 = b; pc = p; imm = im;
    pred_taken = pred; out_ready = ordy; flush = fl;
  endtask

  // One clock: check in_ready, advance the model, then check registered outputs.
  task automatic runCycle();
    bit expReady, hs, tk, ill, mis;
    logic [31:0] tgt;
    @(negedge clk);
    expReady = (!mValid || out_ready) && !flush;
    checkOutput("in_ready", {63'd0, in_ready}, {63'd0, expReady});
    hs = mValid && out_ready;
    if (rst) begin
      mValid = 0; mTaken = 0; mMis = 0; mIll = 0; mTarget = 0;
      mBranches = 0; mMispredicts = 0;
    end else begin
      if (hs) begin
        if (mBranches < 64'hFFFF_FFFF) mBranches++;
        if (mMis && mMispredicts < 64'hFFFF_FFFF) mMispredicts++;
      end
      if (flush) mValid = 0;
      else if (in_valid && expReady) begin
        refResolve(funct3, rs1, rs2, pc, imm, pred_taken, tk, ill, mis, tgt);
        mValid = 1; mTaken = tk; mIll = ill; mMis = mis; mTarget = tgt;
      end else if (hs) mValid = 0;
    end
    @(posedge clk);
    #1;
    checkOutput("out_valid", {63'd0, out_valid}, {63'd0, mValid});
    checkOutput("taken", {63'd0, taken}, {63'd0, mTaken});
    checkOutput("target", {32'd0, target}, {32'd0, mTarget});
    checkOutput("mispredict", {63'd0, mispredict}, {63'd0, mMis});
    checkOutput("illegal", {63'd0, illegal}, {63'd0, mIll});
`ifdef BRANCH_RESOLVE_STATS_EN
    checkOutput("branch_count", {32'd0, branch_count}, 64'(mBranches));
    checkOutput("mispredict_count", {32'd0, mispredict_count}, 64'(mMispredicts));
`endif
  endtask

  task automatic randomRequest(input bit r, input bit fullRate);
    logic [31:0] a;
    a = $urandom;
    applyStimulus(r, fullRate ? 1'b1 : ($urandom_range(3) != 0), 3'($urandom_range(7)), a,
                  ($urandom_range(3) == 0) ? a : 32'($urandom), $urandom, $urandom, 1'($urandom),
                  fullRate ? 1'b1 : ($urandom_range(3) != 0),
                  fullRate ? 1'b0 : ($urandom_range(15) == 0));
  endtask

  logic [31:0] heldTarget;

  initial begin
    mValid = 0; mTaken = 0; mMis = 0; mIll = 0; mTarget = 0;
    mBranches = 0; mMispredicts = 0;

    applyStimulus(1, 1, 3'd0, 0, 0, 0, 0, 0, 1, 1);
    runCycle();
    runCycle();
    checkOutput("reset_out_valid", {63'd0, out_valid}, 64'd0);
    checkOutput("reset_target", {32'd0, target}, 64'd0);

    // BEQ taken with a wrong prediction.
    applyStimulus(0, 1, 3'b000, 32'h1234, 32'h1234, 32'h100, 32'h20, 0, 1, 0);
    runCycle();
    checkOutput("beq_valid", {63'd0, out_valid}, 64'd1);
    checkOutput("beq_taken", {63'd0, taken}, 64'd1);
    checkOutput("beq_target", {32'd0, target}, 64'h120);
    checkOutput("beq_mispredict", {63'd0, mispredict}, 64'd1);

    // Signed vs unsigned less-than on the same operands.
    applyStimulus(0, 1, 3'b100, 32'hFFFF_FFFF, 32'd1, 32'h200, 32'h40, 1, 1, 0);
    runCycle();
    checkOutput("blt_taken", {63'd0, taken}, 64'd1);
    applyStimulus(0, 1, 3'b110, 32'hFFFF_FFFF, 32'd1, 32'h200, 32'h40, 1, 1, 0);
    runCycle();
    checkOutput("bltu_taken", {63'd0, taken}, 64'd0);
    checkOutput("bltu_target", {32'd0, target}, 64'h204);

    // Back-pressure for three cycles with a pending request.
    heldTarget = target;
    applyStimulus(0, 1, 3'b001, 32'd5, 32'd6, 32'h300, 32'h8, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      runCycle();
      checkOutput("stall_in_ready", {63'd0, in_ready}, 64'd0);
      checkOutput("stall_target", {32'd0, target}, {32'd0, heldTarget});
    end
    out_ready = 1;
    runCycle();
    checkOutput("resume_valid", {63'd0, out_valid}, 64'd1);
    checkOutput("resume_target", {32'd0, target}, 64'h308);

    // Illegal kind, predicted taken, PC at the top of the address space.
    applyStimulus(0, 1, 3'b010, 32'd1, 32'd1, 32'hFFFF_FFFC, 32'h10, 1, 1, 0);
    runCycle();
    checkOutput("ill_illegal", {63'd0, illegal}, 64'd1);
    checkOutput("ill_taken", {63'd0, taken}, 64'd0);
    checkOutput("ill_mispredict", {63'd0, mispredict}, 64'd1);
    checkOutput("ill_target", {32'd0, target}, 64'd0);

    // Flush with an incoming request while a result is held.
    applyStimulus(0, 1, 3'b000, 32'd7, 32'd7, 32'h400, 32'h4, 0, 0, 1);
    runCycle();
    checkOutput("flush_valid", {63'd0, out_valid}, 64'd0);
    flush = 0; in_valid = 0;
    runCycle();
    checkOutput("flush_dropped", {63'd0, out_valid}, 64'd0);

    // Reset, then 1000 requests at full rate.
    applyStimulus(1, 0, 3'd0, 0, 0, 0, 0, 0, 1, 0);
    runCycle();
    for (int i = 0; i < 1000; i++) begin
      randomRequest(0, 1);
      runCycle();
    end
    in_valid = 0;
    runCycle();
`ifdef BRANCH_RESOLVE_STATS_EN
    checkOutput("count_1000", {32'd0, branch_count}, 64'd1000);
    rst = 1;
    runCycle();
    checkOutput("count_reset", {32'd0, branch_count}, 64'd0);
    checkOutput("mp_count_reset", {32'd0, mispredict_count}, 64'd0);
    rst = 0;
`endif

    // Mixed traffic with stalls, flushes and occasional reset.
    for (int i = 0; i < 1500; i++) begin
      randomRequest($urandom_range(63) == 0, 0);
      runCycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_resolve_unit.md
BRANCH_RESOLVE_UNIT -- requirements
Module: branch_resolve_unit

Interface
REQ-001 The block SHALL take parameter: N, 32, datapath width of operands, PC and immediate.
REQ-002 The block SHALL have one clock and reset, listed first: clk  input  1  rising-edge clock; rst  input  1  synchronous, active-high reset.
REQ-003 The block SHALL have input ports: in_valid  input  1  request valid; in_ready  output  1  block can accept; funct3  input  3  branch kind; rs1  input  N  operand A; rs2  input  N  operand B; pc  input  N  branch PC; imm  input  N  sign-extended offset; pred_taken  input  1  front-end prediction; flush  input  1  discard pending/incoming work.
REQ-004 The block SHALL have output ports: out_valid  output  1  result valid; out_ready  input  1  consumer accepts; taken  output  1  resolved direction; target  output  N  next PC; mispredict  output  1  taken != pred_taken; illegal  output  1  unsupported funct3.

Function
REQ-005 The block SHALL hold one result register; latency from input handshake to out_valid SHALL be exactly 1 cycle.
REQ-006 in_ready SHALL equal (!out_valid || out_ready) && !flush, combinationally.
REQ-007 The block SHALL capture the request when in_valid && in_ready, and SHALL set out_valid=1 on the next edge.
REQ-008 When out_valid && out_ready and no capture occurs, out_valid SHALL clear on the next edge; with simultaneous capture, the new result SHALL replace the old one with no bubble.
REQ-009 While out_valid && !out_ready, all outputs SHALL hold stable.
REQ-010 The funct3 decode SHALL be: 000 BEQ (eq), 001 BNE (!eq), 100 BLT (signed lt), 101 BGE (!signed lt), 110 BLTU (unsigned lt), 111 BGEU (!unsigned lt).
REQ-011 The eq term SHALL come from an instance of comparator_eq on rs1/rs2.
REQ-012 For funct3 010/011, the block SHALL register illegal=1, taken=0, and target=pc+4.
REQ-013 target SHALL be pc+imm when taken, else pc+4, both modulo 2^N, with wrap-around silently ignored.
REQ-014 mispredict SHALL be registered as taken XOR pred_taken; for illegal requests it SHALL be pred_taken.
REQ-015 When flush=1, the block SHALL drop any same-cycle input, and out_valid SHALL be 0 on the next edge; a handshake completing in the flush cycle SHALL count as delivered.

Reset
REQ-016 While rst=1 at an edge, the block SHALL clear out_valid, taken, mispredict and illegal to 0, and target to 0; rst SHALL override flush and capture.
REQ-017 in_ready SHALL be 1 in the first cycle after reset deasserts, unless flush is 1.
REQ-018 Reset mid-transfer SHALL discard the held result without producing an output handshake.

Configuration
REQ-019 When macro BRANCH_RESOLVE_STATS_EN is defined, the block SHALL add outputs branch_count (output, 32) and mispredict_count (output, 32).
REQ-020 Under BRANCH_RESOLVE_STATS_EN, the counters SHALL increment on each output handshake (mispredict_count only when mispredict=1), SHALL saturate at 32'hFFFFFFFF, and SHALL reset to 0.
REQ-021 Without BRANCH_RESOLVE_STATS_EN, the counter ports and logic SHALL be absent, with behaviour otherwise identical.

Structure
REQ-022 Package branch_pkg SHALL hold the funct3 enum (BEQ, BNE, BLT, BGE, BLTU, BGEU) and the PC increment constant 4.
REQ-023 comparator_eq SHALL be the sole sub-module; lt/ltu and adders SHALL be inline.
REQ-024 Expected RTL size SHALL be 120-400 lines.

Verification
REQ-025 BEQ with rs1=rs2=0x1234, pc=0x100, imm=0x20, pred=0 -> next cycle: out_valid=1, taken=1, target=0x120, mispredict=1.
REQ-026 BLT with rs1=0xFFFFFFFF, rs2=1 -> taken=1; BLTU with the same operands -> taken=0, target=pc+4.
REQ-027 out_ready=0 for 3 cycles with in_valid=1 -> outputs stable, in_ready=0; out_ready=1 -> next request captured back-to-back with no bubble.
REQ-028 funct3=010, pred=1 -> illegal=1, taken=0, mispredict=1; and pc=0xFFFFFFFC, not taken -> target=0x0 (wrap).
REQ-029 flush together with in_valid while out_valid=1 -> out_valid=0 next cycle, input dropped, counters unchanged.
REQ-030 STATS_EN: 1000 random requests versus a reference model, all accepted -> branch_count=1000, and mispredict_count equals the model's count; rst mid-run -> both counters 0.
